// File: rtl/nes_bus_pkg.sv
// Shared NES CPU-bus definitions: register addresses and the sprite DMA state encoding.
package nes_bus_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;

    localparam logic [ADDR_W-1:0] NES_DMA_REG_ADDR   = 16'h4014;
    localparam logic [ADDR_W-1:0] NES_SPR_DATA_ADDR  = 16'h2004;
    localparam logic [ADDR_W-1:0] NES_PPU_BASE       = 16'h2000;
    localparam logic [ADDR_W-1:0] NES_PPU_LAST       = 16'h2007;
    localparam logic [ADDR_W-1:0] NES_APU_IO_BASE    = 16'h4000;
    localparam logic [ADDR_W-1:0] NES_APU_IO_LAST    = 16'h4017;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } dma_state_t;

endpackage

// File: rtl/spr_dma_ctrl_if.sv
// CPU-side and memory-side bus bundle around the sprite DMA engine.
interface spr_dma_ctrl_if;
    import nes_bus_pkg::*;

    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_wen;
    logic              cpu_ren;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rdy;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wen;
    logic              mem_ren;
    logic [DATA_W-1:0] mem_rdata;
    logic              dma_busy;
    logic              dma_done;

    modport master (
        output cpu_addr, cpu_wdata, cpu_wen, cpu_ren, mem_rdata,
        input  cpu_rdata, cpu_rdy, mem_addr, mem_wdata, mem_wen, mem_ren,
               dma_busy, dma_done
    );

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_wen, cpu_ren, mem_rdata,
        output cpu_rdata, cpu_rdy, mem_addr, mem_wdata, mem_wen, mem_ren,
               dma_busy, dma_done
    );

endinterface

// File: rtl/spr_dma_ctrl.sv
// Sprite DMA engine: snoops CPU writes to 4014h, stalls the CPU and copies a 256-byte page to 2004h.
// Define SPR_DMA_ODD_ALIGN_EN to insert the extra ALIGN cycle when the transfer starts on an odd cycle.
module spr_dma_ctrl
    import nes_bus_pkg::*;
#(
    parameter logic [ADDR_W-1:0] DMA_REG_ADDR  = NES_DMA_REG_ADDR,
    parameter logic [ADDR_W-1:0] SPR_DATA_ADDR = NES_SPR_DATA_ADDR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_wen,
    input  logic              cpu_ren,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rdy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wen,
    output logic              mem_ren,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              dma_busy,
    output logic              dma_done
);

    dma_state_t        state_q, state_d;
    logic [DATA_W-1:0] page_q,  page_d;
    logic [DATA_W-1:0] idx_q,   idx_d;
    logic [DATA_W-1:0] byte_q,  byte_d;
    logic              done_q,  done_d;
`ifdef SPR_DMA_ODD_ALIGN_EN
    logic              par_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            page_q  <= '0;
            idx_q   <= '0;
            byte_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            idx_q   <= idx_d;
            byte_q  <= byte_d;
            done_q  <= done_d;
        end
    end

`ifdef SPR_DMA_ODD_ALIGN_EN
    // Free-running cycle parity, sampled in HALT to decide on the alignment cycle.
    always_ff @(posedge clk) begin
        if (rst) par_q <= 1'b0;
        else     par_q <= ~par_q;
    end
`endif

    // Next-state logic and the bus mux: CPU owns the bus only in IDLE.
    always_comb begin
        state_d   = state_q;
        page_d    = page_q;
        idx_d     = idx_q;
        byte_d    = byte_q;
        done_d    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wen   = 1'b0;
        mem_ren   = 1'b0;

        unique case (state_q)
            IDLE: begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_wen   = cpu_wen;
                mem_ren   = cpu_ren;
                if (cpu_wen && (cpu_addr == DMA_REG_ADDR)) begin
                    page_d  = cpu_wdata;
                    idx_d   = '0;
                    state_d = HALT;
                end
            end
            HALT: begin
`ifdef SPR_DMA_ODD_ALIGN_EN
                state_d = par_q ? ALIGN : READ;
`else
                state_d = READ;
`endif
            end
            ALIGN: state_d = READ;
            READ: begin
                mem_ren  = 1'b1;
                mem_addr = {page_q, idx_q};
                byte_d   = mem_rdata;
                state_d  = WRITE;
            end
            WRITE: begin
                mem_wen   = 1'b1;
                mem_addr  = SPR_DATA_ADDR;
                mem_wdata = byte_q;
                idx_d     = idx_q + 8'd1;
                if (idx_q == 8'hFF) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = READ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cpu_rdata = mem_rdata;
    assign cpu_rdy   = (state_q == IDLE);
    assign dma_busy  = (state_q != IDLE);
    assign dma_done  = done_q;

endmodule
